// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory answering controller read and
// write strobes. Reads return after RD_LAT cycles, writes are acknowledged
// with a one-cycle pulse, and illegal or overlapping strobes pulse err.
// Optional feature: define MEM_INIT_EN to clear the whole memory (one word
// per cycle) after every reset before the first request is accepted.
//
// Handshake: a strobe is taken only when busy=0. M_re alone starts a read,
// M_we alone starts a write. Both together, or any strobe while busy=1, is
// dropped and answered with a one-cycle err pulse. rd_valid and wr_ack are
// single-cycle pulses with no back-pressure; rdata is zero outside rd_valid.
module data_mem_responder #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int RD_LAT = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                M_re,
  input  logic                                M_we,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr,
  input  logic [WIDTH-1:0]                    wdata,
  output logic [WIDTH-1:0]                    rdata,
  output logic                                rd_valid,
  output logic                                wr_ack,
  output logic                                busy,
  output logic                                err,
  output logic [2:0]                          dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Last value of the READ-state counter before moving to RESP.
  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3
`ifdef MEM_INIT_EN
    , INIT = 3'd4
`endif
  } state_t;

  state_t             r_state;
  logic [2:0]         r_lat_cnt;
  logic [AW-1:0]      r_addr;
  logic [WIDTH-1:0]   r_rdata;
  logic               r_rd_valid;
  logic               r_wr_ack;
  logic               r_err;
  logic [WIDTH-1:0]   r_mem [DEPTH];
`ifdef MEM_INIT_EN
  logic [AW-1:0]      r_init_cnt;
`endif

  logic               w_accept_wr;
  logic               w_mem_we;
  logic [AW-1:0]      w_mem_addr;
  logic [WIDTH-1:0]   w_mem_wdata;

  // Memory write port select: accepted controller write, or the init sweep.
  always_comb begin
    w_accept_wr = (r_state == IDLE) && M_we && !M_re;
    w_mem_we    = !reset && w_accept_wr;
    w_mem_addr  = addr;
    w_mem_wdata = wdata;
`ifdef MEM_INIT_EN
    if (!reset && (r_state == INIT)) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_init_cnt;
      w_mem_wdata = '0;
    end
`endif
  end

  // Storage array; deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Control FSM with registered pulse outputs; reset overrides every strobe.
  always_ff @(posedge clk) begin
    r_rd_valid <= 1'b0;
    r_rdata    <= '0;
    r_wr_ack   <= 1'b0;
    r_err      <= 1'b0;
    if (reset) begin
      r_lat_cnt <= '0;
      r_addr    <= '0;
`ifdef MEM_INIT_EN
      r_state    <= INIT;
      r_init_cnt <= '0;
`else
      r_state   <= IDLE;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (M_re && M_we) begin
            r_err <= 1'b1;
          end else if (M_re) begin
            r_addr    <= addr;
            r_lat_cnt <= 3'd1;
            r_state   <= (RD_LAT == 1) ? RESP : READ;
          end else if (M_we) begin
            r_wr_ack <= 1'b1;
            r_state  <= WRITE;
          end
        end
        READ: begin
          if (M_re || M_we) r_err <= 1'b1;
          if (r_lat_cnt == LAT_LAST) begin
            r_state <= RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        WRITE: begin
          if (M_re || M_we) r_err <= 1'b1;
          r_state <= IDLE;
        end
        RESP: begin
          if (M_re || M_we) r_err <= 1'b1;
          r_rd_valid <= 1'b1;
          r_rdata    <= r_mem[r_addr];
          r_state    <= IDLE;
        end
`ifdef MEM_INIT_EN
        INIT: begin
          if (M_re || M_we) r_err <= 1'b1;
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == AW'(DEPTH - 1)) r_state <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign rd_valid  = r_rd_valid;
  assign wr_ack    = r_wr_ack;
  assign err       = r_err;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed bench for data_mem_responder. A main
// instance uses RD_LAT=2; two extra instances (RD_LAT=1 and 4) share clock
// and reset and are only driven during the latency sweep.
module tb_data_mem_responder;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 4;
`ifdef MEM_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             m_re = 1'b0, m_we = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic             s_re = 1'b0, s_we = 1'b0;
  logic [AW-1:0]    s_addr = '0;
  logic [WIDTH-1:0] s_wdata = '0;

  logic [WIDTH-1:0] rdata, rdata_1, rdata_4;
  logic             rd_valid, rd_valid_1, rd_valid_4;
  logic             wr_ack, wr_ack_1, wr_ack_4;
  logic             busy, busy_1, busy_4;
  logic             err, err_1, err_4;
  logic [2:0]       dbg_state, dbg_state_1, dbg_state_4;

  int checks = 0;
  int failures = 0;

  data_mem_responder #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .M_re(m_re), .M_we(m_we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rd_valid(rd_valid), .wr_ack(wr_ack), .busy(busy), .err(err),
    .dbg_state(dbg_state));

  data_mem_responder #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset), .M_re(s_re), .M_we(s_we), .addr(s_addr), .wdata(s_wdata),
    .rdata(rdata_1), .rd_valid(rd_valid_1), .wr_ack(wr_ack_1), .busy(busy_1), .err(err_1),
    .dbg_state(dbg_state_1));

  data_mem_responder #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(4)) dut_l4 (
    .clk(clk), .reset(reset), .M_re(s_re), .M_we(s_we), .addr(s_addr), .wdata(s_wdata),
    .rdata(rdata_4), .rd_valid(rd_valid_4), .wr_ack(wr_ack_4), .busy(busy_4), .err(err_4),
    .dbg_state(dbg_state_4));

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    m_we = 1'b1; addr = a; wdata = d;
    tick();
    m_we = 1'b0;
    tick();
  endtask

  // Returns the number of edges after acceptance until rd_valid (10 = none).
  task automatic do_read(input logic [AW-1:0] a, output logic [WIDTH-1:0] d, output int lat);
    m_re = 1'b1; addr = a;
    tick();
    m_re = 1'b0;
    lat = 0;
    while (!rd_valid && lat < 10) begin
      tick();
      lat++;
    end
    d = rdata;
  endtask

  task automatic test_reset();
    int n;
    logic [2:0] exp_st;
    exp_st = INIT_EN ? 3'd4 : 3'd0;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL reset_wr_ack: got %b expected 0", wr_ack); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    checks++; if (busy !== INIT_EN) begin failures++; $display("FAIL reset_busy: got %b expected %b", busy, INIT_EN); end
    checks++; if (dbg_state !== exp_st) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, exp_st); end
    checks++; if (dbg_state_1 !== exp_st) begin failures++; $display("FAIL reset_state_l1: got %0d expected %0d", dbg_state_1, exp_st); end
    checks++; if (dbg_state_4 !== exp_st) begin failures++; $display("FAIL reset_state_l4: got %0d expected %0d", dbg_state_4, exp_st); end
    reset = 1'b0;
    wait_idle(n);
    checks++; if (n !== (INIT_EN ? DEPTH : 0)) begin failures++; $display("FAIL reset_busy_cycles: got %0d expected %0d", n, INIT_EN ? DEPTH : 0); end
  endtask

  task automatic test_write();
    logic [WIDTH-1:0] d;
    int lat;
    m_we = 1'b1; addr = 4'd3; wdata = 8'hA5;
    tick();
    m_we = 1'b0;
    checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL write_ack: got %b expected 1", wr_ack); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy: got %b expected 1", busy); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL write_no_rd_valid: got %b expected 0", rd_valid); end
    tick();
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL write_ack_pulse: got %b expected 0", wr_ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_done_idle: got %b expected 0", busy); end
    do_read(4'd3, d, lat);
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL write_readback: got %h expected a5", d); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL read_latency: got %0d expected 2", lat); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL rdata_zero_after: got %h expected 00", rdata); end
  endtask

  task automatic test_latency_sweep();
    int lats[3];
    logic v[3];
    logic b[3];
    logic [WIDTH-1:0] r[3];
    lats = '{2, 1, 4};
    m_we = 1'b1; s_we = 1'b1; addr = 4'd0; s_addr = 4'd0; wdata = 8'h5A; s_wdata = 8'h5A;
    tick();
    m_we = 1'b0; s_we = 1'b0;
    tick();
    m_re = 1'b1; s_re = 1'b1;
    tick();
    m_re = 1'b0; s_re = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      v = '{rd_valid, rd_valid_1, rd_valid_4};
      b = '{busy, busy_1, busy_4};
      r = '{rdata, rdata_1, rdata_4};
      for (int i = 0; i < 3; i++) begin
        checks++; if (v[i] !== (k == lats[i])) begin failures++; $display("FAIL sweep_valid lat=%0d k=%0d: got %b expected %b", lats[i], k, v[i], (k == lats[i])); end
        checks++; if (b[i] !== (k < lats[i])) begin failures++; $display("FAIL sweep_busy lat=%0d k=%0d: got %b expected %b", lats[i], k, b[i], (k < lats[i])); end
        checks++; if (r[i] !== ((k == lats[i]) ? 8'h5A : 8'h00)) begin failures++; $display("FAIL sweep_rdata lat=%0d k=%0d: got %h expected %h", lats[i], k, r[i], (k == lats[i]) ? 8'h5A : 8'h00); end
      end
    end
  endtask

  task automatic test_collision();
    logic [WIDTH-1:0] d;
    int lat;
    do_write(4'd5, 8'h11);
    m_re = 1'b1; m_we = 1'b1; addr = 4'd5; wdata = 8'hFF;
    tick();
    m_re = 1'b0; m_we = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL collision_err: got %b expected 1", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL collision_busy: got %b expected 0", busy); end
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL collision_wr_ack: got %b expected 0", wr_ack); end
    tick();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL collision_err_pulse: got %b expected 0", err); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL collision_no_read: got %b expected 0", rd_valid); end
    do_read(4'd5, d, lat);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL collision_mem_kept: got %h expected 11", d); end
    tick();
  endtask

  task automatic test_busy_strobe();
    logic [WIDTH-1:0] d;
    int lat;
    do_write(4'd7, 8'h22);
    do_write(4'd4, 8'h44);
    m_re = 1'b1; addr = 4'd4;
    tick();
    m_re = 1'b0; m_we = 1'b1; addr = 4'd7; wdata = 8'h99;
    tick();
    m_we = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL busy_strobe_err: got %b expected 1", err); end
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL busy_strobe_wr_ack: got %b expected 0", wr_ack); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_strobe_busy: got %b expected 1", busy); end
    tick();
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL busy_strobe_read_valid: got %b expected 1", rd_valid); end
    checks++; if (rdata !== 8'h44) begin failures++; $display("FAIL busy_strobe_read_data: got %h expected 44", rdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL busy_strobe_err_pulse: got %b expected 0", err); end
    tick();
    do_read(4'd7, d, lat);
    checks++; if (d !== 8'h22) begin failures++; $display("FAIL busy_strobe_mem_kept: got %h expected 22", d); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d;
    int lat;
    do_write(4'd9, 8'h3C);
    do_read(4'd9, d, lat);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL b2b_write_read: got %h expected 3c", d); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_lat1: got %0d expected 2", lat); end
    do_read(4'd3, d, lat);
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL b2b_read_read: got %h expected a5", d); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_lat2: got %0d expected 2", lat); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    int n;
    logic seen;
    m_re = 1'b1; addr = 4'd3;
    tick();
    m_re = 1'b0;
    checks++; if (dbg_state !== 3'd1) begin failures++; $display("FAIL mid_read_state: got %0d expected 1", dbg_state); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL mid_read_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (busy !== INIT_EN) begin failures++; $display("FAIL mid_read_busy: got %b expected %b", busy, INIT_EN); end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rd_valid) seen = 1'b1;
    end
    wait_idle(n);
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_read_aborted: got %b expected 0", seen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_read_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_write();
    logic [WIDTH-1:0] d;
    int lat, n;
    logic seen;
    m_we = 1'b1; addr = 4'd2; wdata = 8'h77;
    tick();
    m_we = 1'b0;
    checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL mid_write_ack: got %b expected 1", wr_ack); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL mid_write_ack_cleared: got %b expected 0", wr_ack); end
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (wr_ack) seen = 1'b1;
    end
    wait_idle(n);
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_write_no_ack: got %b expected 0", seen); end
    do_read(4'd2, d, lat);
    checks++; if (d !== (INIT_EN ? 8'h00 : 8'h77)) begin failures++; $display("FAIL mid_write_kept: got %h expected %h", d, INIT_EN ? 8'h00 : 8'h77); end
    tick();
  endtask

  task automatic test_reset_init();
    logic [WIDTH-1:0] d;
    int lat, n;
    do_write(4'd9, 8'h3C);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle(n);
    checks++; if (n !== (INIT_EN ? DEPTH : 0)) begin failures++; $display("FAIL init_busy_cycles: got %0d expected %0d", n, INIT_EN ? DEPTH : 0); end
    do_read(4'd9, d, lat);
    checks++; if (d !== (INIT_EN ? 8'h00 : 8'h3C)) begin failures++; $display("FAIL init_mem_contents: got %h expected %h", d, INIT_EN ? 8'h00 : 8'h3C); end
    tick();
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_write();
    test_latency_sweep();
    test_collision();
    test_busy_strobe();
    test_back_to_back();
    test_reset_mid_read();
    test_reset_mid_write();
    test_reset_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 16: number of memory words.
REQ-002 Parameter WIDTH, default 8: data word width in bits.
REQ-003 Parameter RD_LAT, default 2: read latency in clock cycles; legal range 1..4.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 M_re  input  1  read strobe from the controller; sampled each rising edge.
REQ-007 M_we  input  1  write strobe from the controller; sampled each rising edge.
REQ-008 addr  input  log2(DEPTH)  word address; sampled with the strobe.
REQ-009 wdata  input  WIDTH  write data; sampled with M_we.
REQ-010 rdata  output  WIDTH  read data; valid only while rd_valid=1.
REQ-011 rd_valid  output  1  one-cycle pulse marking the read response.
REQ-012 wr_ack  output  1  one-cycle pulse acknowledging a completed write.
REQ-013 busy  output  1  high while a request or initialisation is in progress; new strobes are not accepted.
REQ-014 err  output  1  one-cycle pulse flagging a protocol violation.

Function
REQ-015 The FSM SHALL have four states: IDLE, READ, WRITE and RESP; encoding is free.
REQ-016 In IDLE with M_re=1 and M_we=0, the block SHALL latch addr and go to READ, or to RESP if RD_LAT=1.
REQ-017 READ SHALL count RD_LAT-1 cycles, then go to RESP.
REQ-018 In RESP, the block SHALL drive rdata=mem[latched addr] and rd_valid=1 for exactly one cycle, then return to IDLE.
REQ-019 Latency: for a read accepted at edge t0, rd_valid SHALL be high in the cycle following edge t0+RD_LAT.
REQ-020 In IDLE with M_we=1 and M_re=0, the block SHALL write wdata to mem[addr] at that edge, go to WRITE, and assert wr_ack for that one cycle.
REQ-021 WRITE SHALL return to IDLE after one cycle; a write therefore occupies 2 cycles including acceptance.
REQ-022 In IDLE with M_re=1 and M_we=1, the block SHALL perform no memory access and no state change, and SHALL pulse err for one cycle.
REQ-023 Any strobe while busy=1 SHALL be ignored and SHALL pulse err for one cycle; the transaction in progress SHALL continue unaffected.
REQ-024 busy SHALL be 1 in READ, WRITE and RESP, and 0 in IDLE.
REQ-025 A read of an address written by the immediately preceding completed write SHALL return the new data.
REQ-026 addr SHALL be used unmodified as the index; with DEPTH a power of two there are no out-of-range addresses.
REQ-027 rdata SHALL be 0 whenever rd_valid=0.

Reset
REQ-028 While reset=1 at a rising edge, the block SHALL enter IDLE; rd_valid, wr_ack and err SHALL be 0, and rdata SHALL be 0.
REQ-029 Reset mid-read SHALL abort the read; no rd_valid SHALL follow.
REQ-030 Reset mid-write SHALL leave the already-written word intact, and no further wr_ack SHALL be issued.
REQ-031 Memory contents SHALL be unaffected by reset unless MEM_INIT_EN is defined.
REQ-032 Reset SHALL take priority over all strobes.

Configuration
REQ-033 Macro MEM_INIT_EN defined: after reset deasserts, the block SHALL enter an INIT state, write 0 to addresses 0..DEPTH-1 at one address per cycle, hold busy=1 for DEPTH cycles, and flag strobes during INIT via err.
REQ-034 Macro MEM_INIT_EN undefined: the INIT state SHALL be absent, and busy SHALL be 0 in the first cycle after reset.

Verification
REQ-035 Write: M_we=1, addr=3, wdata=0xA5 for one cycle -> wr_ack=1 in the next cycle; a later read of addr 3 with RD_LAT=2 -> rdata=0xA5 with rd_valid 2 cycles after acceptance.
REQ-036 Latency sweep: read addr 0 with RD_LAT=1,2,4 -> rd_valid in cycle t0+1, t0+2, t0+4 respectively; busy=1 throughout.
REQ-037 Collision: M_re=1 and M_we=1 together in IDLE, addr=5, wdata=0xFF -> err pulse, mem[5] unchanged, busy stays 0.
REQ-038 Strobe while busy: M_we to addr 7 one cycle after a read is accepted -> err pulse, mem[7] unchanged, original read completes.
REQ-039 Reset mid-read: reset asserted in READ -> IDLE next cycle, no rd_valid, busy=0.
REQ-040 MEM_INIT_EN: preload mem[9]=0x3C, then reset -> busy=1 for 16 cycles, and a subsequent read of addr 9 returns 0x00.
